fp_add_arbiter: RTL and testbench

- Shares one floating-point adder (start/done sequenced datapath) among N_REQ requesters.
- Round-robin grant, operand capture, adder start pulse, done wait with watchdog timeout, per-requester result return.
- Sits between client blocks and the adder, and is the only driver of the adder's start, clr and operand inputs.

---
 rtl/fp_add_pkg.sv | 18 +
 rtl/rr_pick.sv | 29 ++
 rtl/fp_add_arbiter.sv | 138 +++++++++++++
 tb/tb_fp_add_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared definitions for the shared-FP-adder arbiter: FSM encoding and
// single-precision constants that benches use as known operands.
package fp_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO   = 32'h4000_0000;
    localparam logic [31:0] FP_THREE = 32'h4040_0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr_i
// upward, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             any_o,
    output logic [IW-1:0]    idx_o
);

    always_comb begin
        int j;
        j     = 0;
        any_o = 1'b0;
        idx_o = '0;
        // Walk the scan order backwards so the nearest index to ptr_i wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req_i[j]) begin
                any_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one start/done floating-point adder among
// N_REQ clients, with a watchdog that aborts a stuck add via fpu_clr.
module fp_add_arbiter
    import fp_add_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16,
    localparam int IW         = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        resp_valid,
    input  logic [N_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    resp_err,
    output logic                    fpu_start,
    output logic                    fpu_clr,
    output logic [DATA_W-1:0]       fpu_a,
    output logic [DATA_W-1:0]       fpu_b,
    input  logic                    fpu_done,
    input  logic [DATA_W-1:0]       fpu_result,
    output logic                    busy,
    output logic [IW-1:0]           grant_id
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    state_t                         state_q, state_d;
    logic [IW-1:0]                  rr_q, rr_d;
    logic [IW-1:0]                  gnt_q, gnt_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [DATA_W-1:0]              a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]              rdata_q, rdata_d;
    logic                           rerr_q, rerr_d;

    logic [N_REQ-1:0][DATA_W-1:0]   a_vec, b_vec;
    logic                           pick_any;
    logic [IW-1:0]                  pick_idx;

    assign a_vec = req_a;
    assign b_vec = req_b;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;
        req_ready  = '0;
        resp_valid = '0;
        fpu_start  = 1'b0;
        fpu_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Gated by clr_n so no handshake leaks out while held in reset.
                if (pick_any && clr_n) begin
                    req_ready[pick_idx] = 1'b1;
                    a_d     = a_vec[pick_idx];
                    b_d     = b_vec[pick_idx];
                    gnt_d   = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (fpu_done) begin
                    rdata_d = fpu_result;
                    rerr_d  = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    fpu_clr = 1'b1;
                    rdata_d = '0;
                    rerr_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                resp_valid[gnt_q] = 1'b1;
                if (resp_ready[gnt_q]) begin
                    rr_d    = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign resp_data = rdata_q;
    assign resp_err  = rerr_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = gnt_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized bench for fp_add_arbiter with a transaction-level round-robin
// model and a behavioural adder with configurable latency or hang.
module tb_fp_add_arbiter;
    import fp_add_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                 clk, clr_n;
    logic [NR-1:0]        req_valid, req_ready, resp_valid, resp_ready;
    logic [NR-1:0][DW-1:0] ta, tb;
    logic [DW-1:0]        resp_data, fpu_a, fpu_b, fpu_result;
    logic                 resp_err, fpu_start, fpu_clr, fpu_done, busy;
    logic [1:0]           grant_id;

    int nchk = 0, nerr = 0;
    int rr = 0;
    bit hang = 0, poke = 0;
    int lat = 3;

    fp_add_arbiter #(.N_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .clr_n(clr_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(ta), .req_b(tb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .fpu_start(fpu_start), .fpu_clr(fpu_clr),
        .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .busy(busy), .grant_id(grant_id)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fake_sum(logic [31:0] a, logic [31:0] b);
        if (a == FP_ONE && b == FP_TWO) return FP_THREE;
        return a + b + 32'h1;
    endfunction

    function automatic int pick(logic [NR-1:0] rv, int p);
        for (int k = 0; k < NR; k++)
            if (rv[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Adder model: done one cycle, lat cycles after the start pulse.
    initial begin
        int cnt;
        cnt = 0;
        fpu_done = 0;
        fpu_result = '0;
        forever begin
            @(negedge clk);
            fpu_done = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    fpu_done = 1;
                    fpu_result = fake_sum(fpu_a, fpu_b);
                end
            end else if (fpu_start && !hang) begin
                cnt = lat;
            end
            if (poke) begin
                fpu_done = 1;
                fpu_result = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
        end
    endtask

    task automatic run_op(input logic [NR-1:0] rv, input bit hg, input int lt,
                          input int hold, output int g);
        int i, k, clr_at, clr_cnt, start_bad, a_bad;
        logic [31:0] exp_d, hd;
        logic [NR-1:0] m;
        hang = hg;
        lat = lt;
        g = pick(rv, rr);
        req_valid = rv;
        resp_ready = '0;
        #1;
        i = 0;
        while (req_ready == 0 && i < 20) begin
            @(negedge clk); #1; i++;
        end
        chk("grant_lat", i, 0);
        chk("grant", req_ready, NR'(1) << g);
        @(negedge clk); #1;
        req_valid = NR'($urandom);
        chk("start", fpu_start, 1);
        chk("fpu_a", fpu_a, ta[g]);
        chk("fpu_b", fpu_b, tb[g]);
        chk("grant_id", grant_id, g);
        chk("busy", busy, 1);
        exp_d = hg ? 32'h0 : fake_sum(ta[g], tb[g]);
        clr_at = 0; clr_cnt = 0; start_bad = 0; a_bad = 0;
        for (k = 1; k < TO + lt + 8; k++) begin
            @(negedge clk); #1;
            if (resp_valid != 0) break;
            if (fpu_clr) begin clr_at = k; clr_cnt++; end
            if (fpu_start) start_bad++;
            if (fpu_a !== ta[g] || fpu_b !== tb[g]) a_bad++;
        end
        chk("start_in_wait", start_bad, 0);
        chk("op_stable", a_bad, 0);
        if (hg) begin
            chk("clr_at", clr_at, TO);
            chk("clr_cnt", clr_cnt, 1);
            chk("resp_at_to", k, TO + 1);
        end else begin
            chk("clr_cnt", clr_cnt, 0);
            chk("resp_at", k, lt + 1);
        end
        chk("resp_valid", resp_valid, NR'(1) << g);
        chk("resp_data", resp_data, exp_d);
        chk("resp_err", resp_err, hg);
        for (int h = 0; h < hold; h++) begin
            m = NR'($urandom);
            m[g] = 1'b0;
            resp_ready = m;
            req_valid = rv;
            @(negedge clk); #1;
            chk("hold_valid", resp_valid, NR'(1) << g);
            chk("hold_data", resp_data, exp_d);
            chk("hold_ready", req_ready, 0);
            chk("hold_start", fpu_start, 0);
        end
        m = NR'($urandom);
        m[g] = 1'b1;
        resp_ready = m;
        req_valid = '0;
        @(negedge clk); #1;
        chk("release_valid", resp_valid, 0);
        chk("release_busy", busy, 0);
        resp_ready = '0;
        rr = (g + 1) % NR;
    endtask

    initial begin
        int g;
        logic [NR-1:0] rv;
        clr_n = 0;
        req_valid = '0;
        resp_ready = '0;
        ta = '0;
        tb = '0;
        @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_start", fpu_start, 0);
        clr_n = 1;

        // Contention: all requesters held, order 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            rand_ops();
            run_op(4'b1111, 0, 2, 0, g);
            chk("contention_order", g, n % NR);
        end
        // Skip: from rr=1, 0011 grants 1, then 0, then 1.
        rand_ops(); run_op(4'b0011, 0, 2, 0, g); chk("skip1", g, 1);
        rand_ops(); run_op(4'b0011, 0, 2, 0, g); chk("skip0", g, 0);
        rand_ops(); run_op(4'b0011, 0, 2, 0, g); chk("skip1b", g, 1);
        // Single request 1.0 + 2.0, adder latency 3.
        rand_ops(); ta[0] = FP_ONE; tb[0] = FP_TWO;
        run_op(4'b0001, 0, 3, 0, g);
        chk("single_g", g, 0);
        chk("single_data", resp_data, FP_THREE);
        // Timeout, then backpressure.
        rand_ops(); run_op(4'b0110, 1, 3, 0, g);
        rand_ops(); run_op(4'b1000, 0, 4, 5, g);
        // Reset mid-WAIT: first steer rr to 2.
        rand_ops(); run_op(4'b0010, 0, 2, 0, g);
        hang = 1;
        req_valid = 4'b0100;
        #1;
        chk("rst_op_grant", req_ready, 4'b0100);
        @(negedge clk); req_valid = '0;
        @(negedge clk); @(negedge clk); #1;
        clr_n = 0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_rvalid", resp_valid, 0);
        chk("mid_fpu_a", fpu_a, 0);
        chk("mid_fpu_b", fpu_b, 0);
        chk("mid_gid", grant_id, 0);
        chk("mid_clr", fpu_clr, 0);
        chk("mid_start", fpu_start, 0);
        @(negedge clk);
        clr_n = 1;
        hang = 0;
        rr = 0;
        poke = 1;
        @(negedge clk); #1;
        poke = 0;
        @(negedge clk); #1;
        chk("late_done_busy", busy, 0);
        chk("late_done_rvalid", resp_valid, 0);
        rand_ops(); run_op(4'b1111, 0, 2, 0, g);
        chk("post_rst_g", g, 0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            rand_ops();
            rv = NR'($urandom_range(1, 15));
            run_op(rv, ($urandom_range(0, 9) == 0), $urandom_range(1, 6),
                   $urandom_range(0, 3), g);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
